// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Also defines the statistics counter width that is used when FIFO_WR_ARB_STATS_EN is defined.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int STAT_WIDTH = 16;

  // Next round-robin position after idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Returns the first set request scanning upward from rr_ptr_i, wrapping around.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               any_req_o,
  output logic [IDX_W-1:0]   winner_o
);

  int idx;

  // Scan from the farthest offset down so the closest one to rr_ptr_i wins.
  always_comb begin
    any_req_o = |req_i;
    winner_o  = '0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_i[IDX_W'(idx)]) winner_o = IDX_W'(idx);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Define FIFO_WR_ARB_STATS_EN to add saturating per-requester beat and stall counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_WIDTH-1:0] beat_count,
  output logic [STAT_WIDTH-1:0]         stall_count
`endif
);

  localparam int BC_W = $clog2(MAX_BURST + 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic                  any_req;
  logic [IDX_W-1:0]      winner;
  logic                  in_grant, sel_valid, sel_last, xfer, release_grant;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i     (req_valid),
    .rr_ptr_i  (rr_ptr_q),
    .any_req_o (any_req),
    .winner_o  (winner)
  );

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Reset gates the handshake combinationally so no beat moves in the reset cycle.
  always_comb begin
    in_grant      = (state_q == GRANT) && !rst;
    sel_valid     = req_valid[grant_q];
    sel_last      = req_last[grant_q];
    xfer          = in_grant && sel_valid && !fifo_full;
    release_grant = (xfer && (sel_last || beat_cnt_q == BC_W'(MAX_BURST - 1))) || !sel_valid;

    fifo_wr_en   = xfer;
    fifo_wr_data = in_grant ? words[grant_q] : '0;
    req_ready    = (in_grant && !fifo_full) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
    busy         = in_grant;
    grant_id     = grant_q;

    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = GRANT;
          grant_d    = winner;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (xfer) beat_cnt_d = beat_cnt_q + BC_W'(1);
        if (release_grant) begin
          state_d    = IDLE;
          rr_ptr_d   = IDX_W'(rr_next(int'(grant_q), NUM_REQ));
          beat_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stall_q;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + STAT_WIDTH'(1);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    logic [STAT_WIDTH-1:0] beats_q;
    always_ff @(posedge wr_clk) begin
      if (rst)                                    beats_q <= '0;
      else if (xfer && grant_q == IDX_W'(g))      beats_q <= sat_inc(beats_q);
    end
    assign beat_count[g*STAT_WIDTH +: STAT_WIDTH] = beats_q;
  end

  always_ff @(posedge wr_clk) begin
    if (rst)                                stall_q <= '0;
    else if (in_grant && sel_valid && fifo_full) stall_q <= sat_inc(stall_q);
  end

  assign stall_count = stall_q;
`endif

endmodule
